// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial word receiver: FSM encoding, legal word
// widths and the bit-counter sizing helper.
package serial_rx_pkg;

  localparam int WORD_WIDTH_MIN = 2;
  localparam int WORD_WIDTH_MAX = 32;

  typedef logic [0:0] rx_state_t;
  localparam rx_state_t ST_IDLE  = 1'b0;
  localparam rx_state_t ST_SHIFT = 1'b1;

  // Bits needed to count 0..width-1 (minimum 1).
  function automatic int cnt_width(input int width);
    int w;
    w = 1;
    for (int i = 1; i < 6; i++) begin
      if ((1 << w) < width) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// Serial-in / word-out bus of the receiver. With SERIAL_RX_OVERRUN_CNT_EN
// defined the bus also carries the saturating overrun_count.
interface serial_word_receiver_if #(parameter int WORD_WIDTH = 8);

  logic                  sample_edge;
  logic                  frame_active;
  logic                  data_in;
  logic                  data_ready;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  overrun;
  logic                  frame_abort;
`ifdef SERIAL_RX_OVERRUN_CNT_EN
  logic [7:0]            overrun_count;

  modport master (
    output sample_edge, frame_active, data_in, data_ready,
    input  data_out, data_valid, overrun, frame_abort, overrun_count
  );
  modport slave (
    input  sample_edge, frame_active, data_in, data_ready,
    output data_out, data_valid, overrun, frame_abort, overrun_count
  );
`else
  modport master (
    output sample_edge, frame_active, data_in, data_ready,
    input  data_out, data_valid, overrun, frame_abort
  );
  modport slave (
    input  sample_edge, frame_active, data_in, data_ready,
    output data_out, data_valid, overrun, frame_abort
  );
`endif

endinterface

// File: rtl/serial_shift_reg.sv
// Shift register and modulo-WORD_WIDTH bit counter; flags the strobe that
// completes a word and exposes the word as it will look after that shift.
module serial_shift_reg
  import serial_rx_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  localparam int CW        = cnt_width(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic                  clear,
  input  logic                  bit_in,
  output logic [WORD_WIDTH-1:0] word_next,
  output logic [CW-1:0]         count,
  output logic                  complete
);

  localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

  logic [WORD_WIDTH-1:0] shreg;

  always_comb begin
    if (MSB_FIRST) word_next = {shreg[WORD_WIDTH-2:0], bit_in};
    else           word_next = {bit_in, shreg[WORD_WIDTH-1:1]};
  end

  assign complete = shift_en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      count <= '0;
    end else if (clear) begin
      shreg <= '0;
      count <= '0;
    end else if (shift_en) begin
      shreg <= word_next;
      count <= complete ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Frame-qualified serial receiver with a valid/ready word output, overrun and
// frame-abort pulses. Optional feature macro: SERIAL_RX_OVERRUN_CNT_EN.
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  serial_word_receiver_if.slave rx
);

  localparam int CW = cnt_width(WORD_WIDTH);

  rx_state_t             state;
  logic [CW-1:0]         count;
  logic [WORD_WIDTH-1:0] word_next;
  logic                  complete;
  logic                  shift_en;
  logic                  frame_end;
  logic                  accept;
  logic [WORD_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  overrun_q;
  logic                  abort_q;

  // Strobes only count inside a frame and never in the cycle the frame opens.
  assign shift_en  = (state == ST_SHIFT) && rx.frame_active && rx.sample_edge;
  assign frame_end = (state == ST_SHIFT) && !rx.frame_active;
  assign accept    = valid_q && rx.data_ready;

  serial_shift_reg #(
    .WORD_WIDTH (WORD_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_shift (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .shift_en  (shift_en),
    .clear     (frame_end),
    .bit_in    (rx.data_in),
    .word_next (word_next),
    .count     (count),
    .complete  (complete)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (rx.frame_active)  state <= ST_SHIFT;
        default:  if (!rx.frame_active) state <= ST_IDLE;
      endcase
    end
  end

  // A finished word is taken when the holding slot is empty or being drained
  // this very cycle; otherwise it is lost and reported as an overrun.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      overrun_q <= complete && valid_q && !rx.data_ready;
      abort_q   <= frame_end && (count != '0);
      if (complete && (!valid_q || accept)) begin
        data_q  <= word_next;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef SERIAL_RX_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                                   ovr_cnt_q <= '0;
    else if (complete && valid_q && !rx.data_ready && ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
  end

  assign rx.overrun_count = ovr_cnt_q;
`endif

  assign rx.data_out    = data_q;
  assign rx.data_valid  = valid_q;
  assign rx.overrun     = overrun_q;
  assign rx.frame_abort = abort_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench: an MSB-first and an LSB-first receiver share one input
// stream and are compared against a bit-queue reference model.
module tb_serial_word_receiver;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_word_receiver_if #(.WORD_WIDTH(W)) bus_m ();
  serial_word_receiver_if #(.WORD_WIDTH(W)) bus_l ();

  assign bus_l.sample_edge  = bus_m.sample_edge;
  assign bus_l.frame_active = bus_m.frame_active;
  assign bus_l.data_in      = bus_m.data_in;
  assign bus_l.data_ready   = bus_m.data_ready;

  serial_word_receiver #(.WORD_WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .rx        (bus_m)
  );

  serial_word_receiver #(.WORD_WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .rx        (bus_l)
  );

  typedef struct {
    bit         e;
    bit         fa;
    bit         d;
    bit         r;
    bit         v;
    logic [7:0] msb;
    logic [7:0] lsb;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int ovr_seen;
  int abort_seen;

  // Reference model: bits collected in arrival order, word formed arithmetically.
  bit         m_in_frame;
  bit         m_bits[$];
  logic [W-1:0] m_msb;
  logic [W-1:0] m_lsb;
  bit         m_valid;
  bit         m_over;
  bit         m_abort;
  int         m_ocount;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(input bit e, input bit fa, input bit d, input bit r,
                              input bit v, input logic [7:0] msb, input logic [7:0] lsb);
    vec_t t;
    t.e = e; t.fa = fa; t.d = d; t.r = r; t.v = v; t.msb = msb; t.lsb = lsb;
    return t;
  endfunction

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_bits.delete();
    m_msb = '0;
    m_lsb = '0;
    m_valid = 1'b0;
    m_over = 1'b0;
    m_abort = 1'b0;
    m_ocount = 0;
  endtask

  task automatic model_step();
    bit accept;
    bit complete;
    logic [W-1:0] wm;
    logic [W-1:0] wl;
    accept = m_valid && bus_m.data_ready;
    complete = 1'b0;
    m_over = 1'b0;
    m_abort = 1'b0;
    wm = '0;
    wl = '0;
    if (m_in_frame && bus_m.frame_active && bus_m.sample_edge) begin
      m_bits.push_back(bus_m.data_in);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = m_bits[i];
          wl[i]     = m_bits[i];
        end
        complete = 1'b1;
        m_bits.delete();
      end
    end
    if (m_in_frame && !bus_m.frame_active) begin
      if (m_bits.size() != 0) m_abort = 1'b1;
      m_bits.delete();
    end
    if (complete) begin
      if (!m_valid || accept) begin
        m_msb = wm;
        m_lsb = wl;
        m_valid = 1'b1;
      end else begin
        m_over = 1'b1;
        if (m_ocount < 255) m_ocount++;
      end
    end else if (accept) begin
      m_valid = 1'b0;
    end
    m_in_frame = bus_m.frame_active;
  endtask

  task automatic checkOutput();
    check("valid_msb", 32'(bus_m.data_valid), 32'(m_valid));
    check("valid_lsb", 32'(bus_l.data_valid), 32'(m_valid));
    check("data_msb", 32'(bus_m.data_out), 32'(m_msb));
    check("data_lsb", 32'(bus_l.data_out), 32'(m_lsb));
    check("overrun_msb", 32'(bus_m.overrun), 32'(m_over));
    check("overrun_lsb", 32'(bus_l.overrun), 32'(m_over));
    check("abort_msb", 32'(bus_m.frame_abort), 32'(m_abort));
    check("abort_lsb", 32'(bus_l.frame_abort), 32'(m_abort));
`ifdef SERIAL_RX_OVERRUN_CNT_EN
    check("overrun_count", 32'(bus_m.overrun_count), 32'(m_ocount));
`endif
    if (bus_m.overrun) ovr_seen++;
    if (bus_m.frame_abort) abort_seen++;
  endtask

  task automatic applyStimulus(input bit e, input bit fa, input bit d, input bit r);
    bus_m.sample_edge  = e;
    bus_m.frame_active = fa;
    bus_m.data_in      = d;
    bus_m.data_ready   = r;
    @(posedge clk);
    model_step();
    #1;
    checkOutput();
  endtask

  // Sends a word MSB-first with up to 'gaps' idle cycles before each strobe.
  task automatic send_word(input logic [7:0] word, input bit rdy_last, input int gaps);
    logic [7:0] w;
    w = word;
    for (int i = 0; i < W; i++) begin
      for (int g = 0; g < int'($urandom_range(gaps, 0)); g++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, w[W-1-i], (i == W-1) ? rdy_last : 1'b0);
    end
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_valid"}, 32'(bus_m.data_valid | bus_l.data_valid), 32'd0);
    check({tag, "_data"}, 32'(bus_m.data_out | bus_l.data_out), 32'd0);
    check({tag, "_pulses"}, 32'({bus_m.overrun, bus_m.frame_abort, bus_l.overrun, bus_l.frame_abort}), 32'd0);
    check({tag, "_count"}, 32'(dut_msb.u_shift.count), 32'd0);
`ifdef SERIAL_RX_OVERRUN_CNT_EN
    check({tag, "_ocount"}, 32'(bus_m.overrun_count), 32'd0);
`endif
  endtask

  task automatic doReset(input bit early);
    bus_m.sample_edge  = 1'b0;
    bus_m.frame_active = 1'b0;
    bus_m.data_in      = 1'b0;
    bus_m.data_ready   = 1'b0;
    rst_n = 1'b0;
    #1;
    if (early) checkZero("reset_async");
    model_reset();
    @(posedge clk);
    #1;
    checkZero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    ovr_seen = 0;
    abort_seen = 0;
  endtask

  initial begin
    vec_t vecs[20];
    logic [7:0] pa;
    logic [7:0] pb;
    bit fa_r;

    model_reset();
    doReset(1'b0);

    // Table: 0xA5 then bits 1,1,0,0,0,0,0,0 (0xC0 MSB-first, 0x03 LSB-first).
    pa = 8'hA5;
    pb = 8'hC0;
    vecs[0] = mk(0, 1, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++)
      vecs[1+i] = mk(1, 1, pa[7-i], 0, i == 7, (i == 7) ? 8'hA5 : 8'h00, (i == 7) ? 8'hA5 : 8'h00);
    vecs[9] = mk(0, 1, 0, 1, 0, 8'hA5, 8'hA5);
    for (int i = 0; i < 8; i++)
      vecs[10+i] = mk(1, 1, pb[7-i], 0, i == 7, (i == 7) ? 8'hC0 : 8'hA5, (i == 7) ? 8'h03 : 8'hA5);
    vecs[18] = mk(0, 0, 0, 1, 0, 8'hC0, 8'h03);
    vecs[19] = mk(0, 0, 0, 0, 0, 8'hC0, 8'h03);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].e, vecs[i].fa, vecs[i].d, vecs[i].r);
      check($sformatf("tbl%0d_valid", i), 32'(bus_m.data_valid), 32'(vecs[i].v));
      check($sformatf("tbl%0d_msb", i), 32'(bus_m.data_out), 32'(vecs[i].msb));
      check($sformatf("tbl%0d_lsb", i), 32'(bus_l.data_out), 32'(vecs[i].lsb));
    end

    // Two words with no consumer: second is dropped with a single overrun.
    doReset(1'b0);
    applyStimulus(0, 1, 0, 0);
    send_word(8'h3C, 1'b0, 2);
    check("ovr_first_data", 32'(bus_m.data_out), 32'h3C);
    send_word(8'hC3, 1'b0, 2);
    applyStimulus(0, 1, 0, 0);
    check("ovr_keep_data", 32'(bus_m.data_out), 32'h3C);
    check("ovr_valid", 32'(bus_m.data_valid), 32'd1);
    check("ovr_pulses", 32'(ovr_seen), 32'd1);
`ifdef SERIAL_RX_OVERRUN_CNT_EN
    check("ovr_count", 32'(bus_m.overrun_count), 32'd1);
`endif

    // Completion coinciding with a drain replaces the word without overrun.
    ovr_seen = 0;
    send_word(8'hC3, 1'b1, 1);
    check("swap_data", 32'(bus_m.data_out), 32'hC3);
    check("swap_valid", 32'(bus_m.data_valid), 32'd1);
    applyStimulus(0, 1, 0, 0);
    check("swap_no_ovr", 32'(ovr_seen), 32'd0);

    // Frame drops after five strobes: one abort, counter cleared, word kept.
    abort_seen = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, i[0], 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    check("abort_pulses", 32'(abort_seen), 32'd1);
    check("abort_count", 32'(dut_msb.u_shift.count), 32'd0);
    check("abort_valid", 32'(bus_m.data_valid), 32'd1);
    check("abort_data", 32'(bus_m.data_out), 32'hC3);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    send_word(8'h81, 1'b0, 1);
    check("after_abort_data", 32'(bus_m.data_out), 32'h81);
    check("after_abort_valid", 32'(bus_m.data_valid), 32'd1);

    // Reset mid-word discards silently; the next frame is clean.
    applyStimulus(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0);
    doReset(1'b1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    check("rst_no_pulses", 32'(abort_seen + ovr_seen), 32'd0);
    send_word(8'h5A, 1'b0, 1);
    check("rst_next_data", 32'(bus_m.data_out), 32'h5A);
    check("rst_next_lsb", 32'(bus_l.data_out), 32'h5A);

    // Randomized traffic against the model.
    fa_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15, 0) == 0) fa_r = ~fa_r;
      applyStimulus(1'($urandom_range(9, 0) < 5), fa_r, 1'($urandom), 1'($urandom_range(9, 0) < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
